// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Package   : mult_pkg
// Purpose   : Shared types and widths for the 12x12 shift-add multiplier.
// Revision  : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Operand width is tied to the 12-bit CLA adder; no other value is supported.
  localparam int N      = 12;
  localparam int PROD_W = 2 * N;

  // Controller states: idle, 12 iterations of add/shift, one-cycle result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_12b_cla12.sv
`default_nettype none
// ============================================================================
// Module    : shift_add_mult_12b_cla12
// Purpose   : 12-bit adder built from four 3-bit carry-lookahead slices,
//             with the slice carries rippling from slice to slice.
// Revision  : 1.0 - initial release
// ============================================================================
module shift_add_mult_12b_cla12 (
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  input  logic        cin_i,
  output logic [11:0] s_o,
  output logic        co_o
);

  // Carry into each 3-bit slice; entry 4 is the final carry out.
  logic [4:0] w_slice_c;

  assign w_slice_c[0] = cin_i;
  assign co_o         = w_slice_c[4];

  for (genvar i = 0; i < 4; i++) begin : g_slice
    logic [2:0] w_g;
    logic [2:0] w_p;
    logic [2:0] w_c;

    assign w_g = x_i[3*i +: 3] & y_i[3*i +: 3];
    assign w_p = x_i[3*i +: 3] ^ y_i[3*i +: 3];

    // Lookahead: every carry in the slice is derived directly from the slice carry-in.
    assign w_c[0] = w_slice_c[i];
    assign w_c[1] = w_g[0] | (w_p[0] & w_slice_c[i]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_slice_c[i]);
    assign w_slice_c[i+1] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                          | (w_p[2] & w_p[1] & w_p[0] & w_slice_c[i]);

    assign s_o[3*i +: 3] = w_p ^ w_c;
  end

endmodule : shift_add_mult_12b_cla12
`default_nettype wire

// File: rtl/shift_add_mult_12b.sv
`default_nettype none
// ============================================================================
// Module    : shift_add_mult_12b
// Purpose   : Sequential 12x12 unsigned multiplier. One CLA addition per
//             iteration, 12 iterations, start/busy/done handshake, 24-bit
//             product held until the next accepted start.
// Revision  : 1.0 - initial release
// ============================================================================
module shift_add_mult_12b
  import mult_pkg::*;
#(
  parameter int CNT_W = 4   // iteration counter; 2**CNT_W must exceed N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  mult_state_t        state_q, state_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [N-1:0]       mq_q, mq_d;
  logic [N-1:0]       mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROD_W-1:0]  product_q, product_d;

  logic [N-1:0]       w_add_y;
  logic [N-1:0]       w_add_s;
  logic               w_add_co;
  logic               w_last_iter;

  // Partial product is added only when the current multiplier LSB is set.
  assign w_add_y     = mq_q[0] ? mcand_q : '0;
  assign w_last_iter = (cnt_q == CNT_W'(N - 1));

  shift_add_mult_12b_cla12 u_cla (
    .x_i   (acc_q),
    .y_i   (w_add_y),
    .cin_i (1'b0),
    .s_o   (w_add_s),
    .co_o  (w_add_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is honoured only in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (w_last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath next state: operand capture, then add and 25-bit right shift of {Co,S,mq}.
  // The product register is loaded on the final shift so it becomes visible
  // on the same edge that raises done.
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = {w_add_co, w_add_s[N-1:1]};
        mq_d  = {w_add_s[0], mq_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (w_last_iter) product_d = {w_add_co, w_add_s[N-1:1], w_add_s[0], mq_q[N-1:1]};
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything including the visible product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule : shift_add_mult_12b
`default_nettype wire

// File: tb/tb_shift_add_mult_12b.sv
`default_nettype none
// ============================================================================
// Module    : tb_shift_add_mult_12b
// Purpose   : Self-checking bench for shift_add_mult_12b; expected products
//             come from plain integer multiplication of the accepted operands.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_12b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] a;
  logic [11:0] b;
  logic        busy;
  logic        done;
  logic [23:0] product;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] last_prod = '0;

  shift_add_mult_12b dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_mult(input logic [11:0] x, input logic [11:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[23:0];
  endfunction

  // One transaction. ign_at > 0: pulse start with a=b=2 at that RUN cycle.
  // rst_at > 0: pull reset at that RUN cycle and abort.
  task automatic run_op(input logic [11:0] ta, input logic [11:0] tb_v,
                        input int ign_at, input int rst_at);
    int          k;
    bit          seen;
    logic [23:0] exp;
    exp = ref_mult(ta, tb_v);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    start = 1'b0; a = 12'($urandom); b = 12'($urandom);
    k = 1;
    check_val("busy_in_run", 32'(busy), 32'd1);
    check_val("product_held_in_run", 32'(product), 32'(last_prod));
    seen = 1'b0;
    while (!seen && k <= 20) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (k == ign_at) begin start = 1'b1; a = 12'h002; b = 12'h002; end
        else start = 1'b0;
        if (k == rst_at) begin
          rst_n = 1'b0;
          #1;
          check_val("abort_busy", 32'(busy), 32'd0);
          check_val("abort_done", 32'(done), 32'd0);
          check_val("abort_product", 32'(product), 32'd0);
          last_prod = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check_val("done_timeout", 32'd0, 32'd1);
    end else begin
      check_val("done_latency", 32'(k), 32'd13);
      check_val("product", 32'(product), 32'(exp));
      check_val("busy_at_done", 32'(busy), 32'd1);
      last_prod = exp;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check_val("single_done_pulse", 32'(done), 32'd0);
        check_val("busy_after_done", 32'(busy), 32'd0);
        check_val("product_stable", 32'(product), 32'(exp));
      end
    end
  endtask

  // start held high: operands are taken every 14 edges, done follows 12 edges later.
  task automatic back_to_back(input int nops);
    logic [23:0] q[$];
    @(negedge clk);
    start = 1'b1; a = 12'($urandom); b = 12'($urandom);
    for (int j = 0; j < 14 * nops; j++) begin
      if (j % 14 == 0) q.push_back(ref_mult(a, b));
      @(negedge clk);
      a = 12'($urandom); b = 12'($urandom);
      if (j + 1 == 14 * nops) start = 1'b0;
      if (j % 14 == 12) begin
        check_val("b2b_done", 32'(done), 32'd1);
        last_prod = q.pop_front();
        check_val("b2b_product", 32'(product), 32'(last_prod));
      end else begin
        check_val("b2b_no_done", 32'(done), 32'd0);
        check_val("b2b_product_stable", 32'(product), 32'(last_prod));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(12'h0FF, 12'h0FF, 0, 0);
    run_op(12'hFFF, 12'hFFF, 0, 0);
    run_op(12'hABC, 12'h001, 0, 0);
    run_op(12'h000, 12'h123, 0, 0);
    run_op(12'h321, 12'h654, 5, 0);
    run_op(12'h7A5, 12'h9C3, 0, 7);
    run_op(12'h7A5, 12'h9C3, 0, 0);
    for (int i = 0; i < 15; i++) begin
      run_op(12'($urandom), 12'($urandom), 0, 0);
    end
    back_to_back(4);
    run_op(12'hFFF, 12'h001, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_shift_add_mult_12b
`default_nettype wire
